// File: rtl/osc_freq_meter_pkg.sv
// Shared definitions for the relaxation-oscillator frequency meter.
// Holds the gate-window FSM state encoding and the legal parameter limits.
// Optional feature macro used by this block: OSC_FREQ_METER_GLITCH_FILTER_EN
// (adds a glitch filter in front of every channel's edge detector).
package osc_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LATCH = 2'd2
  } meter_state_t;

  localparam int NCH_MIN       = 1;
  localparam int NCH_MAX       = 4;
  localparam int CW_MIN        = 4;
  localparam int CW_MAX        = 32;
  localparam int GATE_LOG2_MIN = 2;
  localparam int GATE_LOG2_MAX = 20;

endpackage

// File: rtl/osc_edge_det.sv
// Per-channel front end: 2-flop synchroniser, optional glitch filter and
// rising-edge detector. An input change is counted 3 clk cycles later
// (5 cycles with the filter).
// Macro: OSC_FREQ_METER_GLITCH_FILTER_EN enables the glitch filter.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   osc   - raw comparator output, asynchronous to clk
//   rise  - one-cycle pulse per detected rising edge
module osc_edge_det
  import osc_freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic osc,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic level;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= osc;
      sync2 <= sync1;
    end
  end

`ifdef OSC_FREQ_METER_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  // The filtered level only follows the input once three consecutive
  // samples agree; otherwise it holds its previous value, which is exactly
  // what prev already stores.
  always_comb begin
    level = prev;
    if (sync2 && hist1 && hist2) begin
      level = 1'b1;
    end else if (!sync2 && !hist1 && !hist2) begin
      level = 1'b0;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/osc_freq_meter.sv
// Multi-channel relaxation-oscillator frequency meter. Counts rising edges
// of each oscillator over a gate window of 2**GATE_LOG2 clk cycles, latches
// the counts (saturating, with overflow flags) and exposes them bytewise.
// Macro: OSC_FREQ_METER_GLITCH_FILTER_EN enables per-channel glitch filters.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   en      - measurement enable; dropping it mid-window aborts the window
//   osc_in  - NCH comparator outputs, asynchronous to clk
//   rd_ch   - result channel select (channels >= NCH read as zero)
//   rd_sel  - byte select within the selected result
//   rd_data - combinational byte of the selected latched result
//   valid   - one-cycle pulse when new results are latched
//   busy    - high while a gate window is running
//   ovf     - per-channel saturation flags of the latched results
module osc_freq_meter
  import osc_freq_meter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CW        = 16,
  parameter int GATE_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] osc_in,
  input  logic [1:0]     rd_ch,
  input  logic [1:0]     rd_sel,
  output logic [7:0]     rd_data,
  output logic           valid,
  output logic           busy,
  output logic [NCH-1:0] ovf
);

  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

  meter_state_t         state;
  meter_state_t         state_next;
  logic [GATE_LOG2-1:0] gate_cnt;
  logic [NCH-1:0]       rise;
  logic [CW-1:0]        cnt    [NCH];
  logic [NCH-1:0]       sat;
  logic [CW-1:0]        result [NCH];
  logic [31:0]          res_pad [4];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    osc_edge_det u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .osc  (osc_in[g]),
      .rise (rise[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort on a dropped enable takes priority over ending the window.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!en) begin
          state_next = ST_IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        valid      = 1'b1;
        state_next = en ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (state == ST_RUN && en) begin
      gate_cnt <= gate_cnt + 1'b1;
    end else begin
      gate_cnt <= '0;
    end
  end

  // An edge arriving during the latch cycle belongs to the next window, so
  // the counter restarts at 1 rather than 0. Counters stick at all-ones and
  // record the overflow instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        cnt[ch] <= '0;
      end
      sat <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        case (state)
          ST_RUN: begin
            if (!en) begin
              cnt[ch] <= '0;
              sat[ch] <= 1'b0;
            end else if (rise[ch]) begin
              if (&cnt[ch]) begin
                sat[ch] <= 1'b1;
              end else begin
                cnt[ch] <= cnt[ch] + 1'b1;
              end
            end
          end
          ST_LATCH: begin
            cnt[ch] <= {{(CW-1){1'b0}}, rise[ch]};
            sat[ch] <= 1'b0;
          end
          default: begin
            cnt[ch] <= '0;
            sat[ch] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        result[ch] <= '0;
      end
      ovf <= '0;
    end else if (state == ST_LATCH) begin
      for (int ch = 0; ch < NCH; ch++) begin
        result[ch] <= cnt[ch];
      end
      ovf <= sat;
    end
  end

  // Results are zero-padded to four 32-bit slots so that any channel and
  // byte select is in range; missing channels and bytes above CW read zero.
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NCH) begin : g_used
      assign res_pad[g] = 32'(result[g]);
    end else begin : g_unused
      assign res_pad[g] = '0;
    end
  end

  assign rd_data = res_pad[rd_ch][{rd_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_osc_freq_meter.sv
// Self-checking bench for osc_freq_meter. A main instance (NCH=2, CW=8,
// GATE_LOG2=4) is compared against a sample-history reference model; a
// second instance (CW=4, GATE_LOG2=5) exercises counter saturation.
// Macro: OSC_FREQ_METER_GLITCH_FILTER_EN switches the model's filter too.
module tb_osc_freq_meter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] osc;
  logic [1:0] rd_ch;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       valid;
  logic       busy;
  logic [1:0] ovf;

  logic       en_b;
  logic [1:0] osc_b;
  logic [1:0] rd_ch_b;
  logic [1:0] rd_sel_b;
  logic [7:0] rd_data_b;
  logic       valid_b;
  logic       busy_b;
  logic [1:0] ovf_b;

  osc_freq_meter #(.NCH(2), .CW(8), .GATE_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data),
    .valid(valid), .busy(busy), .ovf(ovf)
  );

  osc_freq_meter #(.NCH(2), .CW(4), .GATE_LOG2(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_b), .osc_in(osc_b),
    .rd_ch(rd_ch_b), .rd_sel(rd_sel_b), .rd_data(rd_data_b),
    .valid(valid_b), .busy(busy_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rd_ch;
    logic [1:0] rd_sel;
    logic [7:0] exp_data;
  } rd_vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: level seen by the edge detector for each sampled
  // clock edge. samp holds what each posedge sampled (0 while in reset);
  // flev is the optionally filtered level. A rising edge of the level at
  // sample m is counted on posedge m+2.
  bit samp [2][4096];
  bit flev [2][4096];
  int cyc = 4;
  int last_res [2];

  always @(posedge clk) begin
    logic s;
    if (cyc < 4095) begin
      for (int ch = 0; ch < 2; ch++) begin
        s = rst_n ? osc[ch] : 1'b0;
        samp[ch][cyc] <= s;
`ifdef OSC_FREQ_METER_GLITCH_FILTER_EN
        if (!rst_n) flev[ch][cyc] <= 1'b0;
        else if (s == samp[ch][cyc-1] && s == samp[ch][cyc-2]) flev[ch][cyc] <= s;
        else flev[ch][cyc] <= flev[ch][cyc-1];
`else
        flev[ch][cyc] <= s;
`endif
      end
      cyc <= cyc + 1;
    end
  end

  function automatic int inc(input int ch, input int n);
    if (n < 3) return 0;
    return (flev[ch][n-2] && !flev[ch][n-3]) ? 1 : 0;
  endfunction

  function automatic int count_edges(input int ch, input int a, input int b);
    int sum = 0;
    for (int n = a; n <= b; n++) sum += inc(ch, n);
    return sum;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_osc(input int mode, input int p);
    case (mode)
      0: osc = {1'b0, ((cyc % 4) < 2)};
      1: osc = 2'($urandom_range(0, 3));
      default: osc = {1'b0, (((cyc - p) % 17) == 7)};
    endcase
  endtask

  // Starts a measurement from IDLE with en held high, runs nwin complete
  // windows, checks busy/valid every cycle and the latched results after
  // each valid. Returns on the negedge after the last result check.
  task automatic applyStimulus(input int nwin, input int mode, input int exp_first);
    int p, t, phase, k, a, c;
    bit pend;
    int exp_r [2];
    bit [1:0] exp_o;
    en = 1'b1;
    p = cyc;
    drive_osc(mode, p);
    pend = 1'b0;
    k = 0;
    while (k < nwin || pend) begin
      @(negedge clk);
      t = cyc - (p + 1);
      phase = t % 17;
      checkOutput("busy", 32'(busy), 32'(phase < 16));
      checkOutput("valid", 32'(valid), 32'(phase == 16));
      if (pend) begin
        for (int ch = 0; ch < 2; ch++) begin
          rd_ch = 2'(ch);
          rd_sel = 2'd0;
          #1;
          checkOutput(ch == 0 ? "result0" : "result1", 32'(rd_data), 32'(exp_r[ch]));
          last_res[ch] = exp_r[ch];
        end
        checkOutput("ovf", 32'(ovf), 32'(exp_o));
        if (k == 1 && exp_first >= 0) begin
          checkOutput("first_window_result0", 32'(last_res[0]), 32'(exp_first));
        end
        pend = 1'b0;
      end
      if (phase == 16) begin
        a = (k == 0) ? cyc - 16 : cyc - 17;
        for (int ch = 0; ch < 2; ch++) begin
          c = count_edges(ch, a, cyc - 1);
          exp_r[ch] = (c > 255) ? 255 : c;
          exp_o[ch] = (c > 255);
        end
        pend = 1'b1;
        k++;
      end
      drive_osc(mode, p);
    end
  endtask

  rd_vec_t rst_tab [6];
  rd_vec_t rd_tab [8];

  initial begin
    int pb;
    bit seen;

    rst_tab[0] = '{2'd0, 2'd0, 8'h00};
    rst_tab[1] = '{2'd0, 2'd1, 8'h00};
    rst_tab[2] = '{2'd1, 2'd0, 8'h00};
    rst_tab[3] = '{2'd2, 2'd0, 8'h00};
    rst_tab[4] = '{2'd3, 2'd3, 8'h00};
    rst_tab[5] = '{2'd1, 2'd2, 8'h00};

    rst_n = 1'b0; en = 1'b0; osc = 2'b00; rd_ch = 2'd0; rd_sel = 2'd0;
    en_b = 1'b0; osc_b = 2'b00; rd_ch_b = 2'd0; rd_sel_b = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd_ch = rst_tab[i].rd_ch;
      rd_sel = rst_tab[i].rd_sel;
      #1;
      checkOutput("reset_rd_data", 32'(rd_data), 32'(rst_tab[i].exp_data));
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Period-4 oscillator on channel 0, one window, then abort at gate 8
`ifdef OSC_FREQ_METER_GLITCH_FILTER_EN
    applyStimulus(1, 0, 0);
`else
    applyStimulus(1, 0, 4);
`endif
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      drive_osc(0, 0);
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd_ch = 2'd0; rd_sel = 2'd0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_valid", 32'(valid), 32'd0);
      checkOutput("abort_result0", 32'(rd_data), 32'(last_res[0]));
      checkOutput("abort_ovf", 32'(ovf), 32'd0);
      drive_osc(0, 0);
    end

    // Byte/channel select table against the held results
    rd_tab[0] = '{2'd0, 2'd0, 8'(last_res[0])};
    rd_tab[1] = '{2'd0, 2'd1, 8'h00};
    rd_tab[2] = '{2'd1, 2'd0, 8'(last_res[1])};
    rd_tab[3] = '{2'd1, 2'd1, 8'h00};
    rd_tab[4] = '{2'd2, 2'd0, 8'h00};
    rd_tab[5] = '{2'd3, 2'd0, 8'h00};
    rd_tab[6] = '{2'd3, 2'd3, 8'h00};
    rd_tab[7] = '{2'd0, 2'd3, 8'h00};
    for (int i = 0; i < 8; i++) begin
      rd_ch = rd_tab[i].rd_ch;
      rd_sel = rd_tab[i].rd_sel;
      #1;
      checkOutput("rd_select", 32'(rd_data), 32'(rd_tab[i].exp_data));
    end

    // Random oscillator activity over continuous windows
    @(negedge clk);
    applyStimulus(5, 1, -1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("random_stop_busy", 32'(busy), 32'd0);

    // Reset asserted at gate count 5 discards the window
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_osc(1, 0);
      @(negedge clk);
    end
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    osc = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      rd_ch = 2'(ch); rd_sel = 2'd0;
      #1;
      checkOutput("midreset_rd_data", 32'(rd_data), 32'd0);
    end
    checkOutput("midreset_valid", 32'(valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, -1);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // A single one-cycle pulse per window
`ifdef OSC_FREQ_METER_GLITCH_FILTER_EN
    applyStimulus(2, 2, 0);
`else
    applyStimulus(2, 2, 1);
`endif
    en = 1'b0;
    osc = 2'b00;
    repeat (2) @(negedge clk);

    // Saturation on the narrow-counter instance, input toggling every cycle
    en_b = 1'b1;
    osc_b = 2'b01;
    pb = cyc;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (valid_b) begin
        seen = 1'b1;
        checkOutput("sat_valid_time", 32'(cyc - pb), 32'd33);
        checkOutput("sat_busy_in_latch", 32'(busy_b), 32'd0);
      end
      osc_b = {1'b0, ~osc_b[0]};
    end
    checkOutput("sat_valid_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rd_ch_b = 2'd0; rd_sel_b = 2'd0;
    #1;
`ifdef OSC_FREQ_METER_GLITCH_FILTER_EN
    checkOutput("sat_result0", 32'(rd_data_b), 32'h00);
    checkOutput("sat_ovf", 32'(ovf_b), 32'b00);
`else
    checkOutput("sat_result0", 32'(rd_data_b), 32'h0F);
    checkOutput("sat_ovf", 32'(ovf_b), 32'b01);
`endif
    rd_sel_b = 2'd1;
    #1;
    checkOutput("sat_byte1", 32'(rd_data_b), 32'h00);
    en_b = 1'b0;
    osc_b = 2'b00;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of relaxation-oscillator channels measured, legal range 1..4.
REQ-002 SHALL have parameter CW, default 16: per-channel edge-counter width, legal range 4..32.
REQ-003 SHALL have parameter GATE_LOG2, default 10: gate window length is 2**GATE_LOG2 clk cycles, legal range 2..20.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  measurement enable.
REQ-007 SHALL have port osc_in  input  NCH  comparator outputs, asynchronous to clk.
REQ-008 SHALL have port rd_ch  input  2  result channel select; values >= NCH read as zero.
REQ-009 SHALL have port rd_sel  input  2  byte select of the selected result; bytes above CW read as zero.
REQ-010 SHALL have port rd_data  output  8  combinational byte of the selected latched result.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when new results are latched.
REQ-012 SHALL have port busy  output  1  high while a gate window is running.
REQ-013 SHALL have port ovf  output  NCH  per-channel saturation flag of the latched results.

Function
REQ-014 SHALL pass each osc_in bit through a 2-flop synchroniser, then detect a rising edge as synced=1 with previous synced=0; edge-to-count latency is 3 cycles.
REQ-015 SHALL implement FSM IDLE, RUN, LATCH; reset state IDLE.
REQ-016 IDLE: busy=0, counters held at 0; en=1 -> RUN on the next cycle.
REQ-017 RUN: busy=1, gate counter increments 0..2**GATE_LOG2-1, each channel counter increments on every detected edge; on the gate counter's final value -> LATCH.
REQ-018 LATCH: results and ovf copied from the channel counters, valid=1 for exactly this cycle, gate counter cleared; -> RUN if en=1, else -> IDLE.
REQ-019 In continuous operation valid SHALL pulse every 2**GATE_LOG2+1 cycles.
REQ-020 An edge detected in the LATCH cycle SHALL be counted in the new window: the counter loads 1 instead of 0.
REQ-021 A channel counter SHALL saturate at 2**CW-1 and set that channel's internal overflow bit; it SHALL never wrap.
REQ-022 en=0 during RUN SHALL abort to IDLE next cycle: no valid, counters cleared, latched results and ovf unchanged.
REQ-023 rd_data SHALL equal bits [8*rd_sel+7 : 8*rd_sel] of result[rd_ch], zero-extended.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE and clear synchronisers, counters, results and ovf; valid=0, busy=0, rd_data=0.
REQ-025 Reset asserted mid-window SHALL discard the window; no valid SHALL follow reset release until a full new window completes.

Configuration
REQ-026 With OSC_FREQ_METER_GLITCH_FILTER_EN defined, each synchronised input SHALL pass a 3-sample majority-free filter: the filtered level changes only after 3 consecutive equal samples, adding 2 cycles of latency; pulses shorter than 3 cycles are not counted.
REQ-027 Without OSC_FREQ_METER_GLITCH_FILTER_EN, the synchronised level SHALL feed edge detection directly; no filter logic is present.

Structure
REQ-028 A shared package osc_freq_meter_pkg SHALL hold the FSM state enum and the constants for legal parameter limits.
REQ-029 One sub-module osc_edge_det (synchroniser, optional filter, rising-edge detect) SHALL be instantiated once per channel.

Verification (NCH=2, CW=8, GATE_LOG2=4, filter off unless stated)
REQ-030 en=1, osc_in[0] period 4 cycles, osc_in[1]=0 -> valid every 17 cycles, result0=4, result1=0, ovf=00.
REQ-031 CW=4, GATE_LOG2=5, osc_in[0] period 2 cycles -> result0=15, ovf[0]=1; rd_ch=0, rd_sel=0 -> rd_data=0x0F.
REQ-032 en dropped at gate count 8 after one completed window of result0=4 -> busy=0 next cycle, no valid, result0 still 4.
REQ-033 rst_n pulsed low at gate count 5 -> valid, busy, ovf, rd_data all 0 immediately; first valid 18 cycles after en seen in IDLE.
REQ-034 rd_sel=1 with CW=8, or rd_ch=3 -> rd_data=0x00.
REQ-035 Single 1-cycle high pulse on osc_in[0] per window -> result0=1 without filter macro, 0 with OSC_FREQ_METER_GLITCH_FILTER_EN.
